shared_memory_stream_reader: RTL and testbench
==============================================

Name: shared_memory_stream_reader

Overview:
- Read-side engine for port 2 of the dual-port shared sample memory.
- The HPS writes stereo PCM words into the shared memory; this block fetches a programmed window of words at fixed one-cycle read latency.
- It buffers the words in a small FIFO and presents them as a valid/ready sample stream to the audio output path (codec serializer).
- Supports single-shot and loop playback, plus abort.

Parameters:
ADDR_W, 15, word address width of the memory port
DATA_W, 32, memory word width; word = {left[31:16], right[15:0]}
FIFO_DEPTH, 4, output buffer depth in words; power of two, >=2

Ports:
clk  in  1  single clock, shared with memory port 2
reset_n  in  1  synchronous, active-low reset
start  in  1  1-cycle pulse; latches base_addr/length/loop; ignored while busy
stop  in  1  1-cycle pulse; aborts transfer; wins over start in same cycle
base_addr  in  ADDR_W  first word address
length  in  ADDR_W+1  number of words, 0..2^ADDR_W
loop  in  1  1 = restart at base_addr after last word
address2  out  ADDR_W  memory read address
chipselect2  out  1  memory select; high only on read-issue cycles
write2  out  1  tied 0
byteenable2  out  4  tied 4'hF
clken2  out  1  tied 1
readdata2  in  DATA_W  memory data, valid exactly 1 cycle after issue
sample_data  out  DATA_W  FIFO head word
sample_valid  out  1  FIFO not empty
sample_ready  in  1  consumer accepts head when valid&ready
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on normal completion (not on stop)

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE; FIFO empty; in-flight=0.
  - address2=0, chipselect2=0, sample_valid=0, sample_data=0, busy=0, done=0.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start with length!=0: latch cfg, cur_addr=base_addr, remaining=length -> FETCH.
  - start with length==0: pulse done next cycle, stay IDLE, no reads issued.
- FETCH:
  - Issue a read (chipselect2=1, address2=cur_addr) in any cycle where fifo_count + inflight < FIFO_DEPTH (credit rule; inflight is 0 or 1).
  - On issue: cur_addr += 1, wrapping modulo 2^ADDR_W; remaining -= 1.
  - The cycle after an issue, readdata2 is written into the FIFO unconditionally. Credit guarantees space.
  - Last word issued, loop=0: -> DRAIN.
  - Last word issued, loop=1: cur_addr=base_addr, remaining=length latched; stay FETCH with no bubble (back-to-back issue allowed).
- DRAIN:
  - No new issues.
  - When inflight=0 and FIFO empty: -> IDLE, pulse done in the same cycle as the transition.
- FIFO:
  - Pop on sample_valid & sample_ready.
  - Simultaneous push and pop in the same cycle is legal; count unchanged.
  - sample_data is combinational from the head entry.
  - Full-throughput steady state: one word per cycle with sample_ready held high.
- stop in FETCH/DRAIN:
  - Next state IDLE; FIFO flushed; any in-flight return discarded.
  - chipselect2=0 from the next cycle; no done pulse.
- stop in IDLE: no effect.
- start while busy: ignored; cfg unchanged.
- Latency: first chipselect2 one cycle after start. First sample_valid three cycles after start (issue, return, FIFO visible).
- reset_n asserted mid-transfer: same as reset; no done pulse.
- Backpressure: with sample_ready=0, at most FIFO_DEPTH words are fetched, then chipselect2 stays 0 until a pop.
- Address wrap: base_addr=0x7FFE, length=4 reads 0x7FFE, 0x7FFF, 0x0000, 0x0001.

Test Plan:
- Basic single-shot:
  - Stimulus: mem[0x100..0x107]=0xA0000000+i; start base=0x100 len=8 loop=0; sample_ready=1.
  - Response: 8 samples 0xA0000000..0xA0000007 in order on consecutive cycles; done pulses once; busy falls with done; exactly 8 chipselect2 cycles.
- Backpressure:
  - Stimulus: same window, sample_ready=0 for 20 cycles, then 1.
  - Response: exactly 4 reads issued, then stall; all 8 words delivered in order, none lost or duplicated.
- Wrap and zero length:
  - Stimulus: base=0x7FFE len=4; then start with len=0.
  - Response: first start reads addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001. Second start pulses done next cycle with zero chipselect2 cycles.
- Loop:
  - Stimulus: base=0x20 len=3 loop=1, sample_ready=1 for 12 cycles of output.
  - Response: data sequence repeats words 0x20, 0x21, 0x22 four times; no gap at the loop boundary; no done.
- Abort:
  - Stimulus: stop asserted while a read is in flight and FIFO holds 2 words.
  - Response: next cycle sample_valid=0, busy=0, chipselect2=0, no done. A following start works normally from a clean FIFO.
- Reset mid-operation:
  - Stimulus: reset_n=0 for 1 cycle during FETCH.
  - Response: all outputs at reset values next cycle; start/stop pulses during reset ignored.

Source files
------------

// File: rtl/shared_memory_stream_reader.sv
// Streams a programmed window of shared-memory words through a small FIFO as a valid/ready sample stream.
// Single-shot or looping playback; stop aborts and flushes.
module shared_memory_stream_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop,
  output logic [ADDR_W-1:0] address2,
  output logic              chipselect2,
  output logic              write2,
  output logic [3:0]        byteenable2,
  output logic              clken2,
  input  logic [DATA_W-1:0] readdata2,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cur_addr_reg;
  logic [ADDR_W-1:0]   cfg_base_reg;
  logic [ADDR_W:0]     remaining_reg;
  logic [ADDR_W:0]     cfg_len_reg;
  logic                cfg_loop_reg;
  logic                inflight_reg;

  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [CNT_W-1:0]    count_reg;

  logic                pop;
  logic                push;
  logic [CNT_W-1:0]    count_next;
  logic [CNT_W:0]      credit;
  logic                can_issue;
  logic                issue_go;
  logic [ADDR_W-1:0]   iss_addr;
  logic [ADDR_W-1:0]   iss_base;
  logic [ADDR_W:0]     iss_rem;
  logic [ADDR_W:0]     iss_len;
  logic                iss_loop;

  assign write2       = 1'b0;
  assign byteenable2  = 4'hF;
  assign clken2       = 1'b1;
  assign busy         = (state_reg != IDLE);
  assign sample_valid = (count_reg != '0);
  assign sample_data  = sample_valid ? fifo_mem[rd_ptr_reg] : '0;

  // chipselect2 is the read being issued now; it becomes in flight next cycle,
  // so it must be counted against FIFO space when deciding the next issue.
  always_comb begin
    pop        = sample_valid & sample_ready;
    push       = inflight_reg;
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    credit     = {1'b0, count_next} + (CNT_W+1)'(chipselect2);
    can_issue  = (credit < (CNT_W+1)'(FIFO_DEPTH));
    if (state_reg == IDLE) begin
      iss_addr = base_addr;
      iss_base = base_addr;
      iss_rem  = length;
      iss_len  = length;
      iss_loop = loop;
      issue_go = start && (length != '0);
    end else begin
      iss_addr = cur_addr_reg;
      iss_base = cfg_base_reg;
      iss_rem  = remaining_reg;
      iss_len  = cfg_len_reg;
      iss_loop = cfg_loop_reg;
      issue_go = (state_reg == FETCH) && can_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= readdata2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      cfg_base_reg  <= '0;
      remaining_reg <= '0;
      cfg_len_reg   <= '0;
      cfg_loop_reg  <= 1'b0;
      inflight_reg  <= 1'b0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      address2      <= '0;
      chipselect2   <= 1'b0;
      done          <= 1'b0;
    end else begin
      done         <= 1'b0;
      chipselect2  <= 1'b0;
      inflight_reg <= chipselect2;
      count_reg    <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      if (stop) begin
        // Flush everything; a pending return is dropped by clearing inflight.
        state_reg    <= IDLE;
        inflight_reg <= 1'b0;
        count_reg    <= '0;
        rd_ptr_reg   <= '0;
        wr_ptr_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && (length == '0)) begin
              done <= 1'b1;
            end else if (issue_go) begin
              cfg_base_reg <= base_addr;
              cfg_len_reg  <= length;
              cfg_loop_reg <= loop;
              state_reg    <= FETCH;
            end
          end
          DRAIN: begin
            if (!chipselect2 && !inflight_reg && (count_reg == '0)) begin
              state_reg <= IDLE;
              done      <= 1'b1;
            end
          end
          default: ;
        endcase

        if (issue_go) begin
          chipselect2 <= 1'b1;
          address2    <= iss_addr;
          if (iss_rem == (ADDR_W+1)'(1)) begin
            if (iss_loop) begin
              cur_addr_reg  <= iss_base;
              remaining_reg <= iss_len;
            end else begin
              state_reg <= DRAIN;
            end
          end else begin
            cur_addr_reg  <= iss_addr + ADDR_W'(1);
            remaining_reg <= iss_rem - (ADDR_W+1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_memory_stream_reader.sv
// Directed + randomized bench for shared_memory_stream_reader against a memory model and
// an expected-stream model derived from window/loop rules.
module tb_shared_memory_stream_reader;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic          sample_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] address2;
  logic          chipselect2, write2, clken2;
  logic [3:0]    byteenable2;
  logic [DW-1:0] readdata2 = '0;
  logic [DW-1:0] sample_data;
  logic          sample_valid, busy, done;

  shared_memory_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .base_addr(base_addr), .length(length), .loop(loop),
    .address2(address2), .chipselect2(chipselect2), .write2(write2),
    .byteenable2(byteenable2), .clken2(clken2), .readdata2(readdata2),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Shared memory port 2: one-cycle registered read.
  logic [DW-1:0] mem [MSIZE];
  always @(posedge clk) readdata2 <= mem[address2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got[$];
  int            pop_cyc[$];
  logic [AW-1:0] issued[$];
  int            cs_cyc[$];
  int            done_cnt = 0, done_busy_bad = 0, credit_bad = 0, first_valid = -1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && sample_ready) begin
        got.push_back(sample_data);
        pop_cyc.push_back(cyc);
      end
      if (chipselect2) begin
        issued.push_back(address2);
        cs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
      if (sample_valid && first_valid < 0) first_valid = cyc;
      if (issued.size() - got.size() > DEPTH) credit_bad++;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    got.delete(); pop_cyc.delete(); issued.delete(); cs_cyc.delete();
    done_cnt = 0; done_busy_bad = 0; credit_bad = 0; first_valid = -1;
  endtask

  task automatic pulse_start(input int b, input int l, input logic lp, output int sc);
    @(posedge clk); #1;
    base_addr = AW'(b); length = (AW+1)'(l); loop = lp; start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  function automatic logic [31:0] exp_word(input int b, input int l, input int i);
    return mem[(b + (i % l)) % MSIZE];
  endfunction

  // Expected stream: words base..base+len-1 (mod memory size), repeated if looping.
  task automatic check_stream(input string tag, input int b, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] obs;
      obs = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      chk($sformatf("%s_word%0d", tag, i), obs, exp_word(b, l, i));
    end
  endtask

  task automatic check_addrs(input string tag, input int b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] obs;
      obs = (i < issued.size()) ? 32'(issued[i]) : 32'hxxxxxxxx;
      chk($sformatf("%s_addr%0d", tag, i), obs, 32'((b + i) % MSIZE));
    end
  endtask

  initial begin
    int sc, b, l, k;
    for (int i = 0; i < MSIZE; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) mem[16'h100 + i] = 32'hA000_0000 + 32'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_address2", 32'(address2), 32'd0);
    chk("rst_chipselect2", 32'(chipselect2), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_data", sample_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("tie_write2", 32'(write2), 32'd0);
    chk("tie_byteenable2", 32'(byteenable2), 32'hF);
    chk("tie_clken2", 32'(clken2), 32'd1);
    $display("reset: outputs checked");

    // Basic single-shot
    clear_mon();
    sample_ready = 1'b1;
    pulse_start(16'h100, 8, 1'b0, sc);
    wait_done("basic", 100);
    repeat (3) @(negedge clk);
    chk("basic_nsamples", 32'(got.size()), 32'd8);
    check_stream("basic", 16'h100, 8, 8);
    chk("basic_ncs", 32'(issued.size()), 32'd8);
    chk("basic_first_cs", 32'(cs_cyc.size() > 0 ? cs_cyc[0] : -1), 32'(sc + 1));
    chk("basic_first_valid", 32'(first_valid), 32'(sc + 3));
    chk("basic_back_to_back", 32'(pop_cyc.size() == 8 ? pop_cyc[7] - pop_cyc[0] : -1), 32'd7);
    chk("basic_done_once", 32'(done_cnt), 32'd1);
    chk("basic_busy_with_done", 32'(done_busy_bad), 32'd0);
    $display("basic: %0d samples, %0d reads", got.size(), issued.size());

    // Backpressure
    clear_mon();
    sample_ready = 1'b0;
    pulse_start(16'h100, 8, 1'b0, sc);
    repeat (20) @(posedge clk);
    chk("bp_reads_stalled", 32'(issued.size()), 32'd4);
    chk("bp_no_pops", 32'(got.size()), 32'd0);
    #1 sample_ready = 1'b1;
    wait_done("bp", 100);
    repeat (2) @(negedge clk);
    chk("bp_nsamples", 32'(got.size()), 32'd8);
    check_stream("bp", 16'h100, 8, 8);
    chk("bp_ncs", 32'(issued.size()), 32'd8);
    chk("bp_credit", 32'(credit_bad), 32'd0);
    $display("backpressure: %0d samples, %0d reads", got.size(), issued.size());

    // Address wrap
    clear_mon();
    pulse_start(16'h7FFE, 4, 1'b0, sc);
    wait_done("wrap", 100);
    repeat (2) @(negedge clk);
    check_addrs("wrap", 16'h7FFE, 4);
    chk("wrap_ncs", 32'(issued.size()), 32'd4);
    check_stream("wrap", 16'h7FFE, 4, 4);
    $display("wrap: %0d samples", got.size());

    // Zero length
    clear_mon();
    pulse_start(int'($urandom_range(0, MSIZE - 1)), 0, 1'b0, sc);
    @(negedge clk);
    chk("zero_done_next", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("zero_ncs", 32'(issued.size()), 32'd0);
    chk("zero_done_once", 32'(done_cnt), 32'd1);
    $display("zero length: done pulses %0d", done_cnt);

    // Loop
    clear_mon();
    pulse_start(16'h20, 3, 1'b1, sc);
    k = 0;
    while (got.size() < 12 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("loop_12_seen", 32'(got.size() >= 12), 32'd1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    check_stream("loop", 16'h20, 3, 12);
    for (int i = 0; i < 11; i++)
      chk($sformatf("loop_gap%0d", i),
          32'(i + 1 < pop_cyc.size() ? pop_cyc[i+1] - pop_cyc[i] : -1), 32'd1);
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    chk("loop_stopped_busy", 32'(busy), 32'd0);
    $display("loop: %0d samples before stop", got.size());

    // Abort with FIFO holding 2 words and a read in flight
    clear_mon();
    sample_ready = 1'b0;
    b = int'($urandom_range(0, MSIZE - 1));
    pulse_start(b, 16, 1'b0, sc);
    repeat (3) begin @(posedge clk); #1; end
    stop = 1'b1;
    @(negedge clk);
    chk("abort_pre_valid", 32'(sample_valid), 32'd1);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(sample_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cs", 32'(chipselect2), 32'd0);
    chk("abort_data", sample_data, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_nreads", 32'(issued.size()), 32'd4);
    clear_mon();
    sample_ready = 1'b1;
    b = int'($urandom_range(0, MSIZE - 1));
    pulse_start(b, 6, 1'b0, sc);
    wait_done("abort_restart", 100);
    repeat (2) @(negedge clk);
    chk("abort_restart_n", 32'(got.size()), 32'd6);
    check_stream("abort_restart", b, 6, 6);
    $display("abort: restart delivered %0d samples", got.size());

    // Reset mid-operation, with start/stop pulses during reset
    clear_mon();
    b = int'($urandom_range(0, MSIZE - 1));
    pulse_start(b, 12, 1'b0, sc);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0; start = 1'b1; stop = 1'b1; length = 5;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0; stop = 1'b0;
    clear_mon();
    @(negedge clk);
    chk("mrst_address2", 32'(address2), 32'd0);
    chk("mrst_cs", 32'(chipselect2), 32'd0);
    chk("mrst_valid", 32'(sample_valid), 32'd0);
    chk("mrst_data", sample_data, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("mrst_idle_reads", 32'(issued.size()), 32'd0);
    chk("mrst_no_done", 32'(done_cnt), 32'd0);
    pulse_start(b, 5, 1'b0, sc);
    wait_done("mrst_restart", 100);
    repeat (2) @(negedge clk);
    chk("mrst_restart_n", 32'(got.size()), 32'd5);
    check_stream("mrst_restart", b, 5, 5);
    $display("reset mid-op: restart delivered %0d samples", got.size());

    // Randomized windows with random backpressure
    for (int it = 0; it < 16; it++) begin
      clear_mon();
      b = int'($urandom_range(0, MSIZE - 1));
      l = int'($urandom_range(1, 20));
      pulse_start(b, l, 1'b0, sc);
      k = 0;
      while (done_cnt == 0 && k < 600) begin
        @(posedge clk); #1 sample_ready = 1'($urandom_range(0, 1));
        k++;
      end
      chk($sformatf("rnd%0d_done_seen", it), 32'(done_cnt != 0), 32'd1);
      sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk($sformatf("rnd%0d_n", it), 32'(got.size()), 32'(l));
      check_stream($sformatf("rnd%0d", it), b, l, l);
      check_addrs($sformatf("rnd%0d", it), b, l);
      chk($sformatf("rnd%0d_ncs", it), 32'(issued.size()), 32'(l));
      chk($sformatf("rnd%0d_done_once", it), 32'(done_cnt), 32'd1);
      chk($sformatf("rnd%0d_busy_done", it), 32'(done_busy_bad), 32'd0);
      chk($sformatf("rnd%0d_credit", it), 32'(credit_bad), 32'd0);
      $display("random %0d: base %h len %0d samples %0d", it, b, l, got.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
